instr_encoder_loader: RTL

//  Inverse of the instruction decoder: packs opcode/func3/func7/r1/r2/rd/imm/size field bundles into 32-bit
//  RV32 words and streams them into the instruction memory write port at consecutive word addresses.

---
 rtl/instr_encoder_loader.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder_loader
// Function : Packs RV32 field bundles into instruction words and streams them
//            into the instruction-memory write port at consecutive addresses.
//            Optional macro ENC_SELF_CHECK_EN adds a re-decode check (check_err).
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder_loader #(
    parameter int ADDR_W    = 5,
    parameter int MEM_DEPTH = 32,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [6:0]        opcode,
    input  logic [2:0]        func3,
    input  logic [6:0]        func7,
    input  logic [4:0]        r1,
    input  logic [4:0]        r2,
    input  logic [4:0]        rd,
    input  logic [20:0]       imm,
    input  logic              size,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              err_opcode,
`ifdef ENC_SELF_CHECK_EN
    output logic              check_err,
`endif
    output logic              err_full
);

    localparam logic [6:0]        c_OP_R    = 7'b0110011;
    localparam logic [6:0]        c_OP_I    = 7'b0010011;
    localparam logic [6:0]        c_OP_L    = 7'b0000011;
    localparam logic [6:0]        c_OP_S    = 7'b0100011;
    localparam logic [6:0]        c_OP_B    = 7'b1100011;
    localparam logic [6:0]        c_OP_JAL  = 7'b1101111;
    localparam logic [6:0]        c_OP_JALR = 7'b1100111;
    localparam logic [31:0]       c_NOP     = 32'h00000013;
    localparam logic [ADDR_W:0]   c_DEPTH   = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] c_BASE    = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    logic [ADDR_W:0] w_used;
    logic            w_accept;
    logic            w_full_seen;
    logic [31:0]     w_enc;
    logic            w_bad;
    logic [2:0]      w_f3_ls;
    logic            w_unused_imm;

    // A write in flight still occupies a slot until it is counted.
    assign w_used       = count + {{ADDR_W{1'b0}}, mem_we};
    assign in_ready     = (r_state == S_LOAD) && (w_used < c_DEPTH);
    assign w_accept     = in_valid && in_ready;
    assign w_full_seen  = (r_state == S_LOAD) && in_valid && (count == c_DEPTH);
    assign w_f3_ls      = size ? 3'b010 : 3'b000;
    assign w_unused_imm = imm[20];

    always_comb begin
        w_enc = c_NOP;
        w_bad = 1'b0;
        case (opcode)
            c_OP_R:           w_enc = {func7, r2, r1, func3, rd, opcode};
            c_OP_I, c_OP_JALR: w_enc = {imm[11:0], r1, func3, rd, opcode};
            c_OP_L:           w_enc = {imm[11:0], r1, w_f3_ls, rd, opcode};
            c_OP_S:           w_enc = {imm[11:5], r2, r1, w_f3_ls, imm[4:0], opcode};
            c_OP_B:           w_enc = {imm[11], imm[9:4], r2, r1, func3, imm[3:0], imm[10], opcode};
            c_OP_JAL:         w_enc = {imm[19], imm[9:0], imm[10], imm[18:11], rd, opcode};
            default: begin
                w_enc = c_NOP;
                w_bad = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            mem_we     <= 1'b0;
            mem_addr   <= c_BASE;
            mem_wdata  <= 32'h0;
            busy       <= 1'b0;
            done       <= 1'b0;
            count      <= '0;
            err_opcode <= 1'b0;
            err_full   <= 1'b0;
        end else begin
            done   <= 1'b0;
            mem_we <= w_accept;
            if (w_accept) begin
                mem_wdata <= w_enc;
                if (w_bad) err_opcode <= 1'b1;
            end
            if (mem_we) begin
                mem_addr <= mem_addr + ADDR_W'(1);
                count    <= count + (ADDR_W+1)'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_LOAD;
                        busy       <= 1'b1;
                        count      <= '0;
                        mem_addr   <= c_BASE;
                        err_opcode <= 1'b0;
                        err_full   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_full_seen) begin
                        err_full <= 1'b1;
                        // The closing bundle of an overflowing program is dropped.
                        if (in_last) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else if (w_accept && in_last) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ENC_SELF_CHECK_EN
    logic [6:0]  r_op;
    logic [2:0]  r_f3;
    logic [6:0]  r_f7;
    logic [4:0]  r_r1;
    logic [4:0]  r_r2;
    logic [4:0]  r_rd;
    logic [19:0] r_imm;
    logic        r_size;
    logic        w_mismatch;
    logic        w_op_ok, w_rd_ok, w_f3_ok, w_ls_ok, w_r1_ok, w_r2_ok, w_f7_ok;
    logic [11:0] w_i_imm, w_s_imm, w_b_imm;
    logic [19:0] w_j_imm;

    assign w_op_ok = (mem_wdata[6:0]   == r_op);
    assign w_rd_ok = (mem_wdata[11:7]  == r_rd);
    assign w_f3_ok = (mem_wdata[14:12] == r_f3);
    assign w_ls_ok = (mem_wdata[14:12] == (r_size ? 3'b010 : 3'b000));
    assign w_r1_ok = (mem_wdata[19:15] == r_r1);
    assign w_r2_ok = (mem_wdata[24:20] == r_r2);
    assign w_f7_ok = (mem_wdata[31:25] == r_f7);
    assign w_i_imm = mem_wdata[31:20];
    assign w_s_imm = {mem_wdata[31:25], mem_wdata[11:7]};
    assign w_b_imm = {mem_wdata[31], mem_wdata[7], mem_wdata[30:25], mem_wdata[11:8]};
    assign w_j_imm = {mem_wdata[31], mem_wdata[19:12], mem_wdata[20], mem_wdata[30:21]};

    always_comb begin
        w_mismatch = 1'b0;
        case (r_op)
            c_OP_R:            w_mismatch = !(w_op_ok && w_rd_ok && w_f3_ok && w_r1_ok && w_r2_ok && w_f7_ok);
            c_OP_I, c_OP_JALR: w_mismatch = !(w_op_ok && w_rd_ok && w_f3_ok && w_r1_ok && (w_i_imm == r_imm[11:0]));
            c_OP_L:            w_mismatch = !(w_op_ok && w_rd_ok && w_ls_ok && w_r1_ok && (w_i_imm == r_imm[11:0]));
            c_OP_S:            w_mismatch = !(w_op_ok && w_ls_ok && w_r1_ok && w_r2_ok && (w_s_imm == r_imm[11:0]));
            c_OP_B:            w_mismatch = !(w_op_ok && w_f3_ok && w_r1_ok && w_r2_ok && (w_b_imm == r_imm[11:0]));
            c_OP_JAL:          w_mismatch = !(w_op_ok && w_rd_ok && (w_j_imm == r_imm));
            default:           w_mismatch = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= '0;
            r_f3      <= '0;
            r_f7      <= '0;
            r_r1      <= '0;
            r_r2      <= '0;
            r_rd      <= '0;
            r_imm     <= '0;
            r_size    <= 1'b0;
            check_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op   <= opcode;
                r_f3   <= func3;
                r_f7   <= func7;
                r_r1   <= r1;
                r_r2   <= r2;
                r_rd   <= rd;
                r_imm  <= imm[19:0];
                r_size <= size;
            end
            if (mem_we && w_mismatch) check_err <= 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire
